// File: rtl/param_loader_if.sv
// rtl/param_loader_if.sv - Load control, byte stream and BRAM write-port bundle for param_loader; checksum present under PARAM_LOADER_CHECKSUM_EN
interface param_loader_if #(
  parameter int DATA_SIZE = 16
);
  logic                 load_start;
  logic [15:0]          base_addr;
  logic [15:0]          word_count;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 bram_ena;
  logic                 bram_wea;
  logic [15:0]          bram_addra;
  logic [DATA_SIZE-1:0] bram_dina;
  logic                 load_busy;
  logic                 load_done;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [15:0]          checksum;

  modport master (
    output load_start, base_addr, word_count, rx_data, rx_valid,
    input  rx_ready, bram_ena, bram_wea, bram_addra, bram_dina,
    input  load_busy, load_done, checksum
  );

  modport slave (
    input  load_start, base_addr, word_count, rx_data, rx_valid,
    output rx_ready, bram_ena, bram_wea, bram_addra, bram_dina,
    output load_busy, load_done, checksum
  );
`else
  modport master (
    output load_start, base_addr, word_count, rx_data, rx_valid,
    input  rx_ready, bram_ena, bram_wea, bram_addra, bram_dina,
    input  load_busy, load_done
  );

  modport slave (
    input  load_start, base_addr, word_count, rx_data, rx_valid,
    output rx_ready, bram_ena, bram_wea, bram_addra, bram_dina,
    output load_busy, load_done
  );
`endif
endinterface

// File: rtl/param_loader.sv
// rtl/param_loader.sv - Byte-stream to BRAM parameter loader; optional running word checksum under PARAM_LOADER_CHECKSUM_EN
module param_loader #(
  parameter int DATA_SIZE    = 16,
  parameter int WRITE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  param_loader_if.slave bus
);

  localparam int CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_RECV_HI = 5'b00010,
    S_RECV_LO = 5'b00100,
    S_WRITE   = 5'b01000,
    S_DONE    = 5'b10000
  } state_t;

  state_t               state_q;
  logic [15:0]          base_q;
  logic [15:0]          count_q;
  logic [15:0]          index_q;
  logic [7:0]           hi_q;
  logic [CW-1:0]        wcnt_q;
  logic                 rx_ready_q;
  logic                 ena_q;
  logic                 busy_q;
  logic                 done_q;
  logic [15:0]          addra_q;
  logic [DATA_SIZE-1:0] dina_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [15:0]          csum_q;
`endif

  logic accept;
  logic state_ok;

  assign accept   = bus.rx_valid & rx_ready_q;
  // Anything that is not exactly one of the five one-hot codes is treated as corrupt.
  assign state_ok = (state_q == S_IDLE) || (state_q == S_RECV_HI) || (state_q == S_RECV_LO) ||
                    (state_q == S_WRITE) || (state_q == S_DONE);

  // Sequencer: byte handshake, word assembly, timed BRAM write strobe and completion pulse.
  always_ff @(posedge clk) begin
    if (rst || !state_ok) begin
      state_q    <= S_IDLE;
      base_q     <= 16'd0;
      count_q    <= 16'd0;
      index_q    <= 16'd0;
      hi_q       <= 8'd0;
      wcnt_q     <= '0;
      rx_ready_q <= 1'b0;
      ena_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addra_q    <= 16'd0;
      dina_q     <= '0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      csum_q     <= 16'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.load_start) begin
            base_q  <= bus.base_addr;
            count_q <= bus.word_count;
            index_q <= 16'd0;
`ifdef PARAM_LOADER_CHECKSUM_EN
            csum_q  <= 16'd0;
`endif
            if (bus.word_count == 16'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= S_RECV_HI;
              rx_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        S_RECV_HI: begin
          if (accept) begin
            hi_q    <= bus.rx_data;
            state_q <= S_RECV_LO;
          end
        end
        S_RECV_LO: begin
          if (accept) begin
            dina_q     <= DATA_SIZE'({hi_q, bus.rx_data});
            addra_q    <= base_q + index_q;
            ena_q      <= 1'b1;
            wcnt_q     <= '0;
            rx_ready_q <= 1'b0;
            state_q    <= S_WRITE;
`ifdef PARAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q + {hi_q, bus.rx_data};
`endif
          end
        end
        S_WRITE: begin
          if (wcnt_q == CW'(WRITE_CYCLES - 1)) begin
            ena_q   <= 1'b0;
            index_q <= index_q + 16'd1;
            if (index_q + 16'd1 == count_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= S_RECV_HI;
              rx_ready_q <= 1'b1;
            end
          end else begin
            wcnt_q <= wcnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.bram_ena   = ena_q;
  assign bus.bram_wea   = ena_q;
  assign bus.bram_addra = addra_q;
  assign bus.bram_dina  = dina_q;
  assign bus.load_busy  = busy_q;
  assign bus.load_done  = done_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
  assign bus.checksum   = csum_q;
`endif

endmodule

// File: tb/tb_param_loader.sv
// tb/tb_param_loader.sv - Randomized self-checking bench for param_loader against a word-list reference model
`timescale 1ns/1ps
module tb_param_loader;

  localparam int DATA_SIZE = 16;
  localparam int WC        = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_loader_if #(.DATA_SIZE(DATA_SIZE)) bus_if ();

  param_loader #(.DATA_SIZE(DATA_SIZE), .WRITE_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- passive monitor ----------------
  typedef struct {
    int addr;
    int data;
    int len;
    int first;
    int last;
  } wr_t;

  int   cyc = 0;
  wr_t  wr_q[$];
  wr_t  cur;
  int   done_q[$];
  int   done_csum_q[$];
  int   ready_in_write = 0;
  int   wea_ne_ena     = 0;
  int   unstable       = 0;
  int   busy_with_done = 0;
  logic prev_ena       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.bram_wea !== bus_if.bram_ena) wea_ne_ena++;
    if (bus_if.bram_ena === 1'b1) begin
      if (bus_if.rx_ready === 1'b1) ready_in_write++;
      if (!prev_ena) begin
        cur.addr  = int'(bus_if.bram_addra);
        cur.data  = int'(bus_if.bram_dina);
        cur.len   = 1;
        cur.first = cyc;
        cur.last  = cyc;
      end else begin
        if (int'(bus_if.bram_addra) != cur.addr || int'(bus_if.bram_dina) != cur.data) unstable++;
        cur.len++;
        cur.last = cyc;
      end
    end else if (prev_ena) begin
      wr_q.push_back(cur);
    end
    prev_ena = (bus_if.bram_ena === 1'b1);
    if (bus_if.load_done === 1'b1) begin
      done_q.push_back(cyc);
      if (bus_if.load_busy !== 1'b0) busy_with_done++;
`ifdef PARAM_LOADER_CHECKSUM_EN
      done_csum_q.push_back(int'(bus_if.checksum));
`else
      done_csum_q.push_back(0);
`endif
    end
  end

  // ---------------- helpers ----------------
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_bytes[$];
  logic [15:0] cur_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic clear_monitor();
    wr_q.delete();
    done_q.delete();
    done_csum_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, bus_if.rx_ready, 0);
    check({tag, "_ena_wea"}, {bus_if.bram_ena, bus_if.bram_wea}, 0);
    check({tag, "_busy_done"}, {bus_if.load_busy, bus_if.load_done}, 0);
    check({tag, "_addra"}, bus_if.bram_addra, 0);
    check({tag, "_dina"}, bus_if.bram_dina, 0);
`ifdef PARAM_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, bus_if.checksum, 0);
`endif
  endtask

  // Called at #1 after an edge with the DUT idle; returns the stamp of the request cycle.
  task automatic start_load(input logic [15:0] base, input logic [15:0] count, output int start_cyc);
    cur_base             = base;
    bus_if.load_start    = 1'b1;
    bus_if.base_addr     = base;
    bus_if.word_count    = count;
    start_cyc            = cyc;
    @(posedge clk); #1;
    bus_if.load_start    = 1'b0;
    bus_if.base_addr     = 16'($urandom);
    bus_if.word_count    = 16'($urandom);
  endtask

  // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid.
  task automatic send_bytes(input int mode, input int poke_at, input int budget);
    int n = 0;
    bit v;
    while (tx_q.size() > 0 && n < budget) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus_if.rx_valid   = v;
      bus_if.rx_data    = tx_q[0];
      bus_if.load_start = (n == poke_at);
      if (n == poke_at) begin
        bus_if.base_addr  = cur_base ^ 16'h8421;
        bus_if.word_count = 16'd7;
      end
      if (v && bus_if.rx_ready === 1'b1) void'(tx_q.pop_front());
      @(posedge clk); #1;
      n++;
    end
    bus_if.rx_valid   = 1'b0;
    bus_if.load_start = 1'b0;
    check("send_budget_left_bytes", tx_q.size(), 0);
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int n = 0;
    while (bus_if.load_done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", bus_if.load_done, 1);
    if (poke) begin
      bus_if.load_start = 1'b1;
      bus_if.base_addr  = cur_base ^ 16'h1111;
      bus_if.word_count = 16'd2;
    end
    @(posedge clk); #1;
    bus_if.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("idle_after_done", {bus_if.load_busy, bus_if.load_done, bus_if.rx_ready}, 0);
      @(posedge clk); #1;
    end
  endtask

  // Reference: word i lands at (base+i) mod 2^16 holding bytes 2i (high) and 2i+1 (low).
  task automatic verify_load(input string name, input logic [15:0] base, input int count,
                             input int start_cyc, input bit continuous);
    int sum = 0;
    int ea, ed;
    check({name, "_nwrites"}, wr_q.size(), count);
    for (int i = 0; i < count && i < wr_q.size(); i++) begin
      ea  = (int'(base) + i) % 65536;
      ed  = int'(exp_bytes[2*i]) * 256 + int'(exp_bytes[2*i+1]);
      sum = (sum + ed) % 65536;
      check($sformatf("%s_addr%0d", name, i), wr_q[i].addr, ea);
      check($sformatf("%s_data%0d", name, i), wr_q[i].data, ed);
      check($sformatf("%s_len%0d", name, i), wr_q[i].len, WC);
      if (continuous) begin
        if (i == 0) check({name, "_first_write_cycle"}, wr_q[0].first, start_cyc + 3);
        else check($sformatf("%s_word_period%0d", name, i), wr_q[i].first - wr_q[i-1].first, 2 + WC);
      end
    end
    check({name, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) begin
      if (count == 0) check({name, "_done_cycle"}, done_q[0], start_cyc + 1);
      else if (wr_q.size() > 0) check({name, "_done_cycle"}, done_q[0], wr_q[wr_q.size()-1].last + 1);
`ifdef PARAM_LOADER_CHECKSUM_EN
      check({name, "_checksum_at_done"}, done_csum_q[0], sum);
      check({name, "_checksum_held"}, bus_if.checksum, sum);
`endif
    end
    clear_monitor();
  endtask

  task automatic run_load(input string name, input logic [15:0] base, input int count,
                          input int mode, input int poke_at, input bit poke_done);
    int sc;
    exp_bytes = tx_q;
    start_load(base, 16'(count), sc);
    send_bytes(mode, poke_at, 40 * count + 40);
    wait_done(100, poke_done);
    verify_load(name, base, count, sc, mode == 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sc;
    logic [7:0] b1[$];
    rst               = 1'b1;
    bus_if.load_start = 1'b0;
    bus_if.base_addr  = 16'd0;
    bus_if.word_count = 16'd0;
    bus_if.rx_data    = 8'd0;
    bus_if.rx_valid   = 1'b0;
    cur_base          = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    clear_monitor();

    // Known vector: three words from base 50692, valid held high.
    b1 = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    tx_q = b1;
    run_load("known", 16'd50692, 3, 0, -1, 1'b0);
`ifdef PARAM_LOADER_CHECKSUM_EN
    check("known_checksum_const", bus_if.checksum, 16'hBE02);
`endif

    // Same random data, continuous valid then toggling valid.
    fill_random(4);
    b1 = tx_q;
    run_load("cont", 16'($urandom), 2, 0, -1, 1'b0);
    tx_q = b1;
    run_load("toggle", 16'($urandom), 2, 1, -1, 1'b0);

    // Address wrap.
    fill_random(4);
    run_load("wrap", 16'hFFFF, 2, 2, -1, 1'b0);

    // Empty load.
    tx_q.delete();
    run_load("empty", 16'($urandom), 0, 0, -1, 1'b0);

    // Reset after the high byte of word 2 of 3.
    fill_random(6);
    exp_bytes = tx_q;
    start_load(16'h1000, 16'd3, sc);
    while (tx_q.size() > 3) void'(tx_q.pop_back());
    send_bytes(0, -1, 60);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_nwrites", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      check("abort_addr0", wr_q[0].addr, 16'h1000);
      check("abort_data0", wr_q[0].data, int'(exp_bytes[0]) * 256 + int'(exp_bytes[1]));
    end
    check("abort_ndone", done_q.size(), 0);
    clear_monitor();
    fill_random(6);
    run_load("after_abort", 16'($urandom), 3, 2, -1, 1'b0);

    // load_start while busy and during the done cycle must be ignored.
    fill_random(6);
    run_load("busy_start", 16'($urandom), 3, 0, 3, 1'b1);

    // Random loads.
    for (int k = 0; k < 4; k++) begin
      int cnt;
      cnt = $urandom_range(1, 5);
      fill_random(2 * cnt);
      run_load($sformatf("rand%0d", k), 16'($urandom), cnt, $urandom_range(0, 2), -1, 1'b0);
    end

    check("rx_ready_during_write", ready_in_write, 0);
    check("wea_equals_ena", wea_ne_ena, 0);
    check("write_addr_data_stable", unstable, 0);
    check("busy_low_with_done", busy_with_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_loader.md
PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 SHALL provide parameter DATA_SIZE, default 16: BRAM word width in bits, fixed at two bytes.
REQ-002 SHALL provide parameter WRITE_CYCLES, default 4: number of cycles ena/wea are held for each BRAM write.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port base_addr  input  16  first BRAM word address, sampled with load_start.
REQ-007 SHALL have port word_count  input  16  number of words to load, sampled with load_start.
REQ-008 SHALL have port rx_data  input  8  incoming byte.
REQ-009 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-010 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have ports bram_ena (output, 1), bram_wea (output, 1), bram_addra (output, 16) and bram_dina (output, DATA_SIZE), forming the write port of the bias/weights BRAM.
REQ-012 SHALL have port load_busy  output  1  high from load acceptance until the done pulse.
REQ-013 SHALL have port load_done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states S_IDLE, S_RECV_HI, S_RECV_LO, S_WRITE and S_DONE, one-hot encoded.
REQ-015 In S_IDLE, load_start=1 SHALL latch base_addr and word_count, clear the word index and set load_busy, then go to S_DONE if word_count==0, else to S_RECV_HI.
REQ-016 rx_ready SHALL be 1 only in S_RECV_HI and S_RECV_LO; a byte is accepted only when rx_valid and rx_ready are both 1 in the same cycle.
REQ-017 In S_RECV_HI, an accepted byte SHALL be stored as the high byte of the current word, and the state SHALL go to S_RECV_LO; with no accepted byte the state SHALL hold indefinitely (no timeout).
REQ-018 In S_RECV_LO, an accepted byte SHALL register bram_dina={high byte, low byte} and bram_addra=latched base + index, modulo 2^16 (wrap 0xFFFF->0x0000), and the state SHALL go to S_WRITE.
REQ-019 While in S_WRITE, bram_ena and bram_wea SHALL be 1 for exactly WRITE_CYCLES consecutive cycles, and bram_addra and bram_dina SHALL remain stable throughout.
REQ-020 At the end of S_WRITE, ena and wea SHALL drop to 0 and the index SHALL increment; the state SHALL go to S_DONE if index+1==word_count, else to S_RECV_HI.
REQ-021 In S_DONE, load_done SHALL be 1 for one cycle and load_busy SHALL drop; the next state SHALL be S_IDLE.
REQ-022 load_start SHALL be ignored outside S_IDLE, including during S_DONE.
REQ-023 Minimum time per word SHALL be 2 + WRITE_CYCLES cycles when rx_valid is held high.
REQ-024 bram_ena and bram_wea SHALL never be 1 outside S_WRITE.
REQ-025 Any illegal state SHALL recover to S_IDLE with all outputs at reset values.

Reset
REQ-026 When rst=1, the block SHALL enter S_IDLE and drive rx_ready, bram_ena, bram_wea, load_busy and load_done to 0, and bram_addra and bram_dina to 0.
REQ-027 Reset asserted mid-load SHALL abort the load within the same clock edge: any partial word SHALL be discarded, no done pulse SHALL be issued, and words already written SHALL remain in the BRAM.

Configuration
REQ-028 With macro PARAM_LOADER_CHECKSUM_EN defined, the block SHALL provide output checksum[15:0], equal to the modulo-2^16 sum of all words written in the current load; it SHALL be cleared on load acceptance, valid while load_done=1, held until the next load_start or rst, and reset to 0.
REQ-029 Without PARAM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Bench SHALL cover: base 50692, count 3, bytes 12 34 AB CD 00 01 with rx_valid held high -> writes 0x1234@50692, 0xABCD@50693, 0x0001@50694, each with 4-cycle ena/wea; load_done 1 cycle after the last write; checksum 0xBE02 when the macro is defined.
REQ-031 Bench SHALL cover: rx_valid toggling 1/0 every cycle, count 2 -> same written data as with continuous valid; rx_ready never 1 in S_WRITE.
REQ-032 Bench SHALL cover: base 0xFFFF, count 2 -> writes to addresses 0xFFFF then 0x0000.
REQ-033 Bench SHALL cover: count 0 -> no ena pulse; load_done 1 cycle after acceptance; checksum 0.
REQ-034 Bench SHALL cover: rst pulsed after the high byte of word 2 of 3 -> word 1 written, no further writes, no load_done; a new load then completes normally.
REQ-035 Bench SHALL cover: load_start pulsed while busy with different base -> ignored; the original addresses are used.
